acq_sequencer: RTL

Acquisition controller for the clk_100 test-data/ADC path. It owns the free-running 64-slot period counter (clk_100_cnt) and gates the producer enable (ack_en) so acquisition always starts and stops on a period boundary. It counts frames, supports immediate or software-triggered start, and handles frame-limit and stop requests. It forwards producer beats into the DMA FIFO, detects FIFO overflow, and exports status to the PCIe register block.

---
 rtl/acq_sequencer_pkg.sv | 23 ++
 rtl/acq_slot_counter.sv | 25 ++
 rtl/acq_sequencer.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/acq_sequencer_pkg.sv
// Shared definitions for the clk_100 acquisition sequencer: FSM encodings and
// the bit layout of the PCIe status register.
package acq_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARMED = 3'd1,
    ST_SYNC  = 3'd2,
    ST_RUN   = 3'd3,
    ST_DONE  = 3'd4,
    ST_ERR   = 3'd5
  } acq_state_t;

  localparam int STAT_BUSY_BIT = 0;
  localparam int STAT_DONE_BIT = 1;
  localparam int STAT_OVF_BIT  = 2;
  localparam int STAT_W        = 3;

  function automatic logic is_busy(input acq_state_t s);
    return (s == ST_ARMED) || (s == ST_SYNC) || (s == ST_RUN);
  endfunction

endpackage

// File: rtl/acq_slot_counter.sv
// Free-running period slot counter; boundary flags the last slot of a period,
// i.e. the edge on which the counter wraps back to zero.
module acq_slot_counter #(
  parameter int SLOT_BITS = 6
) (
  input  logic                 clk_100,
  input  logic                 clk_100_rst_n,
  output logic [SLOT_BITS-1:0] slot_cnt,
  output logic                 boundary
);

  logic [SLOT_BITS-1:0] cnt_reg;

  always_ff @(posedge clk_100) begin
    if (!clk_100_rst_n) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_reg + SLOT_BITS'(1);
    end
  end

  assign slot_cnt = cnt_reg;
  assign boundary = &cnt_reg;

endmodule

// File: rtl/acq_sequencer.sv
// Acquisition controller: gates the producer on period boundaries, counts frames,
// forwards producer beats to the DMA FIFO and flags FIFO overflow.
module acq_sequencer
  import acq_sequencer_pkg::*;
#(
  parameter int C_DATA_WIDTH = 64,
  parameter int SLOT_BITS    = 6,
  parameter int FRAME_CNT_W  = 32,
  parameter int TCQ          = 1
) (
  input  logic                    clk_100,
  input  logic                    clk_100_rst_n,
  input  logic                    acq_start,
  input  logic                    acq_stop,
  input  logic                    sw_trig,
  input  logic                    trig_mode,
  input  logic [FRAME_CNT_W-1:0]  frame_limit,
  input  logic [C_DATA_WIDTH-1:0] adc_data,
  input  logic                    data_en,
  input  logic                    fifo_full,
  output logic [SLOT_BITS-1:0]    clk_100_cnt,
  output logic                    ack_en,
  output logic                    fifo_wr_en,
  output logic [C_DATA_WIDTH-1:0] fifo_din,
  output logic                    acq_busy,
  output logic                    acq_done,
  output logic                    acq_overflow,
  output logic [FRAME_CNT_W-1:0]  frame_cnt
);

  // TCQ is kept for drop-in compatibility; these registers update with zero delay.
  if (TCQ > 0) begin : g_tcq
  end

  acq_state_t              state_reg, state_next;
  logic                    ack_en_reg, ack_en_next;
  logic                    done_reg, done_next;
  logic                    ovf_reg, ovf_next;
  logic                    stop_pending_reg, stop_pending_next;
  logic [FRAME_CNT_W-1:0]  frame_cnt_reg, frame_cnt_next;
  logic [FRAME_CNT_W-1:0]  limit_reg, limit_next;
  logic                    fifo_wr_en_reg, fifo_wr_en_next;
  logic [C_DATA_WIDTH-1:0] fifo_din_reg, fifo_din_next;
  logic                    boundary;
  logic [FRAME_CNT_W-1:0]  frame_inc;
  logic                    limit_hit;
  logic [STAT_W-1:0]       status_word;

  acq_slot_counter #(
    .SLOT_BITS (SLOT_BITS)
  ) u_slot_counter (
    .clk_100       (clk_100),
    .clk_100_rst_n (clk_100_rst_n),
    .slot_cnt      (clk_100_cnt),
    .boundary      (boundary)
  );

  assign frame_inc = (&frame_cnt_reg) ? frame_cnt_reg : frame_cnt_reg + FRAME_CNT_W'(1);
  assign limit_hit = (limit_reg != '0) && (frame_inc == limit_reg);

  always_comb begin
    state_next        = state_reg;
    ack_en_next       = ack_en_reg;
    done_next         = done_reg;
    ovf_next          = ovf_reg;
    stop_pending_next = stop_pending_reg;
    frame_cnt_next    = frame_cnt_reg;
    limit_next        = limit_reg;

    case (state_reg)
      ST_IDLE, ST_DONE, ST_ERR: begin
        // A coincident stop always beats a start; from ERR it also clears the error state.
        if (acq_stop) begin
          if (state_reg == ST_ERR) state_next = ST_IDLE;
        end else if (acq_start) begin
          frame_cnt_next    = '0;
          done_next         = 1'b0;
          ovf_next          = 1'b0;
          stop_pending_next = 1'b0;
          limit_next        = frame_limit;
          state_next        = trig_mode ? ST_ARMED : ST_SYNC;
        end
      end
      ST_ARMED: begin
        if (acq_stop)     state_next = ST_IDLE;
        else if (sw_trig) state_next = ST_SYNC;
      end
      ST_SYNC: begin
        if (acq_stop) begin
          state_next = ST_IDLE;
        end else if (boundary) begin
          state_next  = ST_RUN;
          ack_en_next = 1'b1;
        end
      end
      ST_RUN: begin
        if (data_en && fifo_full) begin
          state_next  = ST_ERR;
          ack_en_next = 1'b0;
          ovf_next    = 1'b1;
        end else begin
          if (acq_stop) stop_pending_next = 1'b1;
          if (boundary) begin
            frame_cnt_next = frame_inc;
            if (stop_pending_reg || acq_stop || limit_hit) begin
              state_next  = ST_DONE;
              ack_en_next = 1'b0;
              done_next   = 1'b1;
            end
          end
        end
      end
      default: begin
        state_next  = ST_IDLE;
        ack_en_next = 1'b0;
      end
    endcase

    fifo_wr_en_next = data_en & ack_en_reg & ~fifo_full & (state_reg == ST_RUN);
    fifo_din_next   = data_en ? adc_data : fifo_din_reg;
  end

  always_ff @(posedge clk_100) begin
    if (!clk_100_rst_n) begin
      state_reg        <= ST_IDLE;
      ack_en_reg       <= 1'b0;
      done_reg         <= 1'b0;
      ovf_reg          <= 1'b0;
      stop_pending_reg <= 1'b0;
      frame_cnt_reg    <= '0;
      limit_reg        <= '0;
      fifo_wr_en_reg   <= 1'b0;
      fifo_din_reg     <= '0;
    end else begin
      state_reg        <= state_next;
      ack_en_reg       <= ack_en_next;
      done_reg         <= done_next;
      ovf_reg          <= ovf_next;
      stop_pending_reg <= stop_pending_next;
      frame_cnt_reg    <= frame_cnt_next;
      limit_reg        <= limit_next;
      fifo_wr_en_reg   <= fifo_wr_en_next;
      fifo_din_reg     <= fifo_din_next;
    end
  end

  always_comb begin
    status_word                = '0;
    status_word[STAT_BUSY_BIT] = is_busy(state_reg);
    status_word[STAT_DONE_BIT] = done_reg;
    status_word[STAT_OVF_BIT]  = ovf_reg;
  end

  assign acq_busy     = status_word[STAT_BUSY_BIT];
  assign acq_done     = status_word[STAT_DONE_BIT];
  assign acq_overflow = status_word[STAT_OVF_BIT];
  assign ack_en       = ack_en_reg;
  assign frame_cnt    = frame_cnt_reg;
  assign fifo_wr_en   = fifo_wr_en_reg;
  assign fifo_din     = fifo_din_reg;

endmodule
